// File: rtl/evt_ingress_pkg.sv
`default_nettype none
// ============================================================================
// Module   : evt_ingress_pkg
// Brief    : Shared types and helpers for the EVT ingress arbiter.
// Revision : 1.0  initial release
// ============================================================================
package evt_ingress_pkg;

  localparam int EVT_W = 32;

  typedef enum logic {SRC_SENSOR = 1'b0, SRC_UART = 1'b1} src_e;
  typedef enum logic {PRI_SENS = 1'b0, PRI_UART = 1'b1} prio_e;

  // Counter width that never collapses to zero bits.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage
`default_nettype wire

// File: rtl/evt_ingress_outreg.sv
`default_nettype none
// ============================================================================
// Module   : evt_ingress_outreg
// Brief    : One-entry output register in front of the input FIFO. Loads a
//            new word whenever it is empty or draining in the same cycle.
// Revision : 1.0  initial release
// ============================================================================
module evt_ingress_outreg
  import evt_ingress_pkg::*;
#(
  parameter int DATA_W = EVT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              fifo_full_i,
  output logic              load_ok_o,
  output logic              out_valid_o,
  output logic              fifo_wr_en_o,
  output logic [DATA_W-1:0] fifo_wr_data_o
);

  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;

  // A held word never reaches the FIFO during a reset cycle.
  assign fifo_wr_en_o   = out_valid_q & ~fifo_full_i & ~rst;
  assign fifo_wr_data_o = out_data_q;
  assign load_ok_o      = ~out_valid_q | ~fifo_full_i;
  assign out_valid_o    = out_valid_q;

  // Hold register: refills on the same cycle it drains, so no bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (load_ok_o) begin
      out_valid_q <= load_i;
      if (load_i) begin
        out_data_q <= data_i;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/evt_ingress_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : evt_ingress_arbiter
// Brief    : Bounded-burst round-robin arbiter sharing the input-FIFO write
//            port between the sensor stream and the UART event packer, with
//            per-source enables and a sticky FIFO stall detector.
//            Optional macro EVT_INGRESS_STATS_EN adds saturating per-source
//            accept counters; without it cnt_* are tied to zero.
// Revision : 1.0  initial release
// ============================================================================
module evt_ingress_arbiter
  import evt_ingress_pkg::*;
#(
  parameter int DATA_W     = EVT_W,
  parameter int BURST_MAX  = 8,
  parameter int STALL_WARN = 1024,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        cfg_src_en,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] u_data,
  input  logic              u_valid,
  output logic              u_ready,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wr_data,
  input  logic              fifo_full,
  output logic              stall_flag,
  input  logic              stall_clr,
  output logic [CNT_W-1:0]  cnt_sensor,
  output logic [CNT_W-1:0]  cnt_uart
);

  localparam int BW = clog2_min1(BURST_MAX);
  localparam int SW = $clog2(STALL_WARN + 1);
  localparam logic [BW-1:0] c_burst_last = BW'(BURST_MAX - 1);
  localparam logic [SW-1:0] c_stall_warn = SW'(STALL_WARN);

  prio_e          prio_q;
  logic [BW-1:0]  burst_q;
  logic [SW-1:0]  stall_cnt_q;
  logic [SW-1:0]  stall_cnt_d;
  logic           stall_flag_q;

  logic              w_load_ok;
  logic              w_out_valid;
  logic              w_elig_s;
  logic              w_elig_u;
  logic              w_grant_s;
  logic              w_grant_u;
  logic              w_blocked;
  logic [DATA_W-1:0] w_load_data;

  assign w_elig_s = s_valid & cfg_src_en[SRC_SENSOR];
  assign w_elig_u = u_valid & cfg_src_en[SRC_UART];

  // Priority source wins; the other only gets a turn when the favoured one is idle.
  assign w_grant_s = ~rst & w_load_ok & w_elig_s & ((prio_q == PRI_SENS) | ~w_elig_u);
  assign w_grant_u = ~rst & w_load_ok & w_elig_u & ((prio_q == PRI_UART) | ~w_elig_s);

  assign s_ready     = w_grant_s;
  assign u_ready     = w_grant_u;
  assign w_load_data = w_grant_u ? u_data : s_data;

  evt_ingress_outreg #(
    .DATA_W (DATA_W)
  ) u_outreg (
    .clk            (clk),
    .rst            (rst),
    .load_i         (w_grant_s | w_grant_u),
    .data_i         (w_load_data),
    .fifo_full_i    (fifo_full),
    .load_ok_o      (w_load_ok),
    .out_valid_o    (w_out_valid),
    .fifo_wr_en_o   (fifo_wr_en),
    .fifo_wr_data_o (fifo_wr_data)
  );

  // Priority FSM: sensor bursts are capped while UART waits; UART priority lasts one word.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q  <= PRI_SENS;
      burst_q <= '0;
    end else begin
      case (prio_q)
        PRI_SENS: begin
          if (w_grant_s) begin
            if (burst_q == c_burst_last) begin
              if (w_elig_u) begin
                prio_q  <= PRI_UART;
                burst_q <= '0;
              end
            end else begin
              burst_q <= burst_q + BW'(1);
            end
          end else if (w_grant_u) begin
            burst_q <= '0;
          end
        end
        PRI_UART: begin
          // Also fall back when UART has nothing, so priority is never stranded.
          if (w_grant_s | w_grant_u | ~w_elig_u) begin
            prio_q  <= PRI_SENS;
            burst_q <= '0;
          end
        end
        default: begin
          prio_q  <= PRI_SENS;
          burst_q <= '0;
        end
      endcase
    end
  end

  assign w_blocked = w_out_valid & fifo_full;

  // Next stall count: counts consecutive blocked cycles, saturating at the warning level.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_clr || !w_blocked) begin
      stall_cnt_d = '0;
    end else if (stall_cnt_q != c_stall_warn) begin
      stall_cnt_d = stall_cnt_q + SW'(1);
    end
  end

  // Stall counter and sticky flag; a clear beats a set in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      stall_flag_q <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      if (stall_clr) begin
        stall_flag_q <= 1'b0;
      end else if (stall_cnt_d == c_stall_warn) begin
        stall_flag_q <= 1'b1;
      end
    end
  end

  assign stall_flag = stall_flag_q;

`ifdef EVT_INGRESS_STATS_EN
  logic [CNT_W-1:0] cnt_sensor_q;
  logic [CNT_W-1:0] cnt_uart_q;

  // Saturating accept counters, cleared together with the stall status.
  always_ff @(posedge clk) begin
    if (rst || stall_clr) begin
      cnt_sensor_q <= '0;
      cnt_uart_q   <= '0;
    end else begin
      if (w_grant_s && (cnt_sensor_q != '1)) begin
        cnt_sensor_q <= cnt_sensor_q + CNT_W'(1);
      end
      if (w_grant_u && (cnt_uart_q != '1)) begin
        cnt_uart_q <= cnt_uart_q + CNT_W'(1);
      end
    end
  end

  assign cnt_sensor = cnt_sensor_q;
  assign cnt_uart   = cnt_uart_q;
`else
  assign cnt_sensor = '0;
  assign cnt_uart   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_evt_ingress_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_evt_ingress_arbiter
// Brief    : Directed, table-driven bench for evt_ingress_arbiter
//            (BURST_MAX=4, STALL_WARN=16) plus hand-written multi-cycle cases.
// Revision : 1.0  initial release
// ============================================================================
module tb_evt_ingress_arbiter;

`ifdef EVT_INGRESS_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cfg_src_en;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] u_data;
  logic        u_valid;
  logic        u_ready;
  logic        fifo_wr_en;
  logic [31:0] fifo_wr_data;
  logic        fifo_full;
  logic        stall_flag;
  logic        stall_clr;
  logic [15:0] cnt_sensor;
  logic [15:0] cnt_uart;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  evt_ingress_arbiter #(
    .DATA_W     (32),
    .BURST_MAX  (4),
    .STALL_WARN (16),
    .CNT_W      (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_src_en   (cfg_src_en),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .u_data       (u_data),
    .u_valid      (u_valid),
    .u_ready      (u_ready),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_full    (fifo_full),
    .stall_flag   (stall_flag),
    .stall_clr    (stall_clr),
    .cnt_sensor   (cnt_sensor),
    .cnt_uart     (cnt_uart)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  cfg;
    logic        sv;
    logic        uv;
    logic        full;
    logic        clr;
    logic        esr;
    logic        eur;
    logic        ewe;
    logic [31:0] ewd;
  } vec_t;

  localparam int NV = 39;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic r, input logic [1:0] c, input logic sv, input logic uv,
                              input logic f, input logic cl, input logic esr, input logic eur,
                              input logic ewe, input logic [31:0] ewd);
    vec_t v;
    v.rst = r; v.cfg = c; v.sv = sv; v.uv = uv; v.full = f; v.clr = cl;
    v.esr = esr; v.eur = eur; v.ewe = ewe; v.ewd = ewd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [1:0] c, input logic sv, input logic uv,
                       input logic f, input logic cl);
    rst = r; cfg_src_en = c; s_valid = sv; u_valid = uv; fifo_full = f; stall_clr = cl;
  endtask

  initial begin
    // Row = one cycle; data words are tagged with the row index (S=5000_xxxx, U=A000_xxxx).
    tbl[0]  = mk(1, 2'b11, 1, 1, 0, 0, 0, 0, 0, 32'h0);
    tbl[1]  = mk(0, 2'b11, 1, 1, 0, 0, 1, 0, 0, 32'h0);
    tbl[2]  = mk(0, 2'b11, 1, 1, 0, 0, 1, 0, 1, 32'h5000_0001);
    tbl[3]  = mk(0, 2'b11, 1, 1, 0, 0, 1, 0, 1, 32'h5000_0002);
    tbl[4]  = mk(0, 2'b11, 1, 1, 0, 0, 1, 0, 1, 32'h5000_0003);
    tbl[5]  = mk(0, 2'b11, 1, 1, 0, 0, 0, 1, 1, 32'h5000_0004);
    tbl[6]  = mk(0, 2'b11, 1, 1, 0, 0, 1, 0, 1, 32'hA000_0005);
    tbl[7]  = mk(0, 2'b11, 1, 1, 0, 0, 1, 0, 1, 32'h5000_0006);
    tbl[8]  = mk(0, 2'b11, 1, 1, 0, 0, 1, 0, 1, 32'h5000_0007);
    tbl[9]  = mk(0, 2'b11, 1, 1, 0, 0, 1, 0, 1, 32'h5000_0008);
    tbl[10] = mk(0, 2'b11, 1, 1, 0, 0, 0, 1, 1, 32'h5000_0009);
    tbl[11] = mk(0, 2'b11, 1, 1, 1, 0, 0, 0, 0, 32'h0);
    tbl[12] = mk(0, 2'b11, 1, 1, 1, 0, 0, 0, 0, 32'h0);
    tbl[13] = mk(0, 2'b11, 1, 1, 1, 0, 0, 0, 0, 32'h0);
    tbl[14] = mk(0, 2'b11, 1, 1, 1, 0, 0, 0, 0, 32'h0);
    tbl[15] = mk(0, 2'b11, 1, 1, 1, 0, 0, 0, 0, 32'h0);
    tbl[16] = mk(0, 2'b11, 1, 1, 0, 0, 1, 0, 1, 32'hA000_000A);
    tbl[17] = mk(0, 2'b11, 0, 0, 0, 0, 0, 0, 1, 32'h5000_0010);
    tbl[18] = mk(0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    tbl[19] = mk(0, 2'b11, 0, 1, 0, 0, 0, 1, 0, 32'h0);
    tbl[20] = mk(0, 2'b11, 0, 1, 0, 0, 0, 1, 1, 32'hA000_0013);
    tbl[21] = mk(0, 2'b11, 0, 1, 0, 0, 0, 1, 1, 32'hA000_0014);
    tbl[22] = mk(0, 2'b11, 1, 0, 0, 0, 1, 0, 1, 32'hA000_0015);
    tbl[23] = mk(0, 2'b11, 0, 0, 0, 0, 0, 0, 1, 32'h5000_0016);
    tbl[24] = mk(0, 2'b01, 1, 1, 0, 0, 1, 0, 0, 32'h0);
    tbl[25] = mk(0, 2'b01, 1, 1, 0, 0, 1, 0, 1, 32'h5000_0018);
    tbl[26] = mk(0, 2'b01, 1, 1, 0, 0, 1, 0, 1, 32'h5000_0019);
    tbl[27] = mk(0, 2'b01, 1, 1, 0, 0, 1, 0, 1, 32'h5000_001A);
    tbl[28] = mk(0, 2'b11, 1, 1, 0, 0, 1, 0, 1, 32'h5000_001B);
    tbl[29] = mk(0, 2'b11, 1, 1, 0, 0, 0, 1, 1, 32'h5000_001C);
    tbl[30] = mk(0, 2'b11, 0, 0, 0, 0, 0, 0, 1, 32'hA000_001D);
    tbl[31] = mk(0, 2'b11, 1, 1, 0, 0, 1, 0, 0, 32'h0);
    tbl[32] = mk(0, 2'b11, 1, 1, 0, 0, 1, 0, 1, 32'h5000_001F);
    tbl[33] = mk(0, 2'b11, 1, 1, 0, 0, 1, 0, 1, 32'h5000_0020);
    tbl[34] = mk(0, 2'b11, 1, 1, 0, 0, 1, 0, 1, 32'h5000_0021);
    tbl[35] = mk(0, 2'b11, 0, 0, 0, 0, 0, 0, 1, 32'h5000_0022);
    tbl[36] = mk(0, 2'b11, 1, 1, 0, 0, 1, 0, 0, 32'h0);
    tbl[37] = mk(0, 2'b11, 0, 0, 0, 0, 0, 0, 1, 32'h5000_0024);
    tbl[38] = mk(0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 32'h0);

    s_data = '0;
    u_data = '0;
    drive(1, 2'b00, 0, 0, 0, 0);
    tick();

    // Table phase: arbitration order, back-pressure, UART-only, enable, fallback.
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].rst, tbl[i].cfg, tbl[i].sv, tbl[i].uv, tbl[i].full, tbl[i].clr);
      s_data = 32'h5000_0000 + i;
      u_data = 32'hA000_0000 + i;
      #1;
      chk($sformatf("row%0d s_ready", i), {31'b0, s_ready}, {31'b0, tbl[i].esr});
      chk($sformatf("row%0d u_ready", i), {31'b0, u_ready}, {31'b0, tbl[i].eur});
      chk($sformatf("row%0d fifo_wr_en", i), {31'b0, fifo_wr_en}, {31'b0, tbl[i].ewe});
      chk($sformatf("row%0d stall_flag", i), {31'b0, stall_flag}, 32'h0);
      if (tbl[i].ewe) chk($sformatf("row%0d fifo_wr_data", i), fifo_wr_data, tbl[i].ewd);
      tick();
    end
    chk("table cnt_sensor", {16'b0, cnt_sensor}, (STATS != 0) ? 32'd20 : 32'd0);
    chk("table cnt_uart", {16'b0, cnt_uart}, (STATS != 0) ? 32'd6 : 32'd0);

    // Stall detector: 16 blocked cycles set the flag; clear wins over set.
    drive(1, 2'b11, 0, 0, 0, 0);
    tick();
    drive(0, 2'b11, 1, 0, 0, 0);
    s_data = 32'h5A5A_0001;
    #1;
    chk("stall load s_ready", {31'b0, s_ready}, 32'h1);
    tick();
    drive(0, 2'b11, 0, 0, 1, 0);
    for (int k = 0; k < 16; k++) begin
      #1;
      chk($sformatf("stall pre%0d flag", k), {31'b0, stall_flag}, 32'h0);
      chk($sformatf("stall pre%0d wr_en", k), {31'b0, fifo_wr_en}, 32'h0);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("stall set%0d flag", k), {31'b0, stall_flag}, 32'h1);
      tick();
    end
    stall_clr = 1'b1;
    tick();
    stall_clr = 1'b0;
    for (int k = 0; k < 15; k++) begin
      #1;
      chk($sformatf("stall recount%0d flag", k), {31'b0, stall_flag}, 32'h0);
      tick();
    end
    stall_clr = 1'b1;
    tick();
    stall_clr = 1'b0;
    #1;
    chk("stall clr-wins flag", {31'b0, stall_flag}, 32'h0);
    fifo_full = 1'b0;
    #1;
    chk("stall drain wr_en", {31'b0, fifo_wr_en}, 32'h1);
    chk("stall drain data", fifo_wr_data, 32'h5A5A_0001);
    tick();
    chk("stall after drain wr_en", {31'b0, fifo_wr_en}, 32'h0);

    // Stats: 10 sensor then 3 UART accepts after a fresh reset.
    drive(1, 2'b11, 0, 0, 0, 0);
    tick();
    drive(0, 2'b11, 1, 0, 0, 0);
    for (int k = 0; k < 10; k++) tick();
    drive(0, 2'b11, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) tick();
    drive(0, 2'b11, 0, 0, 0, 0);
    tick();
    chk("stats cnt_sensor", {16'b0, cnt_sensor}, (STATS != 0) ? 32'd10 : 32'd0);
    chk("stats cnt_uart", {16'b0, cnt_uart}, (STATS != 0) ? 32'd3 : 32'd0);

    // Reset in the middle of a burst drops the held word.
    drive(0, 2'b11, 1, 1, 0, 0);
    for (int k = 0; k < 3; k++) tick();
    rst = 1'b1;
    #1;
    chk("rst cycle wr_en", {31'b0, fifo_wr_en}, 32'h0);
    chk("rst cycle s_ready", {31'b0, s_ready}, 32'h0);
    chk("rst cycle u_ready", {31'b0, u_ready}, 32'h0);
    tick();
    drive(0, 2'b11, 0, 0, 0, 0);
    #1;
    chk("post rst wr_en", {31'b0, fifo_wr_en}, 32'h0);
    chk("post rst s_ready", {31'b0, s_ready}, 32'h0);
    chk("post rst u_ready", {31'b0, u_ready}, 32'h0);
    chk("post rst stall_flag", {31'b0, stall_flag}, 32'h0);
    chk("post rst cnt_sensor", {16'b0, cnt_sensor}, 32'h0);
    chk("post rst cnt_uart", {16'b0, cnt_uart}, 32'h0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
